// File: rtl/sseg_pkg.sv
// Shared types and segment font for the seven-segment scan driver.
// Segment patterns are active low, bit 6 = a ... bit 0 = g.
package sseg_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_BLANK = 7'b1111111;

    localparam seg_t SEG_TABLE [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

endpackage

// File: rtl/hex2sseg.sv
// Combinational digit decoder: 4-bit code to active-low segments.
// In decimal mode the codes 10-15 render as "0".
module hex2sseg
    import sseg_pkg::*;
(
    input  logic [3:0] code,
    input  logic       hex_en,
    output seg_t       seg
);

    assign seg = (!hex_en && code > 4'd9) ? SEG_TABLE[0] : SEG_TABLE[code];

endmodule

// File: rtl/sseg_scan_driver.sv
// Time-multiplexed common-anode seven-segment driver with PWM brightness,
// leading-zero suppression and tear-free (frame-boundary) value updates.
module sseg_scan_driver
    import sseg_pkg::*;
#(
    parameter int NUM_DIGITS  = 8,
    parameter int DIGIT_CNT_W = 17
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [4*NUM_DIGITS-1:0] value,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    input  logic [NUM_DIGITS-1:0]   blank_in,
    input  logic                    hex_en,
    input  logic                    lzs_en,
    input  logic                    load,
    input  logic [3:0]              bright,
    output logic                    busy,
    output logic                    frame_start,
    output logic [NUM_DIGITS-1:0]   an,
    output logic [6:0]              sseg,
    output logic                    dp
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] ONE_HOT0 = NUM_DIGITS'(1);

    logic [DIGIT_CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]        idx;
    logic                    first;
    logic                    boundary;

    logic [4*NUM_DIGITS-1:0] act_value, sh_value;
    logic [NUM_DIGITS-1:0]   act_dp, sh_dp;
    logic [NUM_DIGITS-1:0]   act_blank, sh_blank;
    logic                    act_hex, sh_hex;
    logic                    act_lzs, sh_lzs;

    logic [NUM_DIGITS-1:0]   lead_zero;
    logic                    above_zero;
    logic [3:0]              cur_code;
    seg_t                    cur_seg;
    logic                    dark;
    logic                    pwm_on;

    // The cycle right after reset counts as a frame boundary so the first
    // load can take effect without waiting a whole frame.
    assign boundary = first | ((&cnt) & (idx == LAST_IDX));

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt   <= '0;
            idx   <= '0;
            first <= 1'b1;
        end else begin
            cnt   <= cnt + 1'b1;
            first <= 1'b0;
            if (&cnt)
                idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
        end
    end

    // A load on the boundary itself bypasses the shadow entirely.
    always_ff @(posedge clk) begin
        if (rst) begin
            act_value <= '0;
            act_dp    <= '0;
            act_blank <= '1;
            act_hex   <= 1'b0;
            act_lzs   <= 1'b0;
            sh_value  <= '0;
            sh_dp     <= '0;
            sh_blank  <= '1;
            sh_hex    <= 1'b0;
            sh_lzs    <= 1'b0;
            busy      <= 1'b0;
        end else if (load && boundary) begin
            act_value <= value;
            act_dp    <= dp_in;
            act_blank <= blank_in;
            act_hex   <= hex_en;
            act_lzs   <= lzs_en;
            busy      <= 1'b0;
        end else if (load) begin
            sh_value  <= value;
            sh_dp     <= dp_in;
            sh_blank  <= blank_in;
            sh_hex    <= hex_en;
            sh_lzs    <= lzs_en;
            busy      <= 1'b1;
        end else if (boundary && busy) begin
            act_value <= sh_value;
            act_dp    <= sh_dp;
            act_blank <= sh_blank;
            act_hex   <= sh_hex;
            act_lzs   <= sh_lzs;
            busy      <= 1'b0;
        end
    end

    // A digit is a leading zero when it and every digit above it are zero.
    always_comb begin
        lead_zero  = '0;
        above_zero = 1'b1;
        for (int i = NUM_DIGITS - 1; i > 0; i--) begin
            above_zero   = above_zero & (act_value[4*i +: 4] == 4'd0);
            lead_zero[i] = above_zero;
        end
    end

    assign cur_code = act_value[{idx, 2'b00} +: 4];
    assign dark     = act_blank[idx] | (act_lzs & lead_zero[idx]);
    assign pwm_on   = cnt[DIGIT_CNT_W-1 -: 4] <= bright;

    hex2sseg u_dec (
        .code   (cur_code),
        .hex_en (act_hex),
        .seg    (cur_seg)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            an          <= '1;
            sseg        <= SEG_BLANK;
            dp          <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            an          <= (!dark && pwm_on) ? ~(ONE_HOT0 << idx) : '1;
            sseg        <= dark ? SEG_BLANK : cur_seg;
            dp          <= dark | ~act_dp[idx];
            frame_start <= (cnt == '0) && (idx == '0);
        end
    end

endmodule

// File: tb/tb_sseg_scan_driver.sv
// Randomised bench for sseg_scan_driver (4 digits, 16-cycle dwell) against a
// cycle-count based reference model of the display.
module tb_sseg_scan_driver;

    localparam int ND = 4;
    localparam int CW = 4;
    localparam int DWELL = 16;
    localparam int FRAME = 64;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] value;
    logic [3:0]  dp_in, blank_in;
    logic        hex_en, lzs_en, load;
    logic [3:0]  bright;
    logic        busy, frame_start;
    logic [3:0]  an;
    logic [6:0]  sseg;
    logic        dp;

    int checks = 0;
    int passes = 0;

    always #5 clk = ~clk;

    sseg_scan_driver #(.NUM_DIGITS(ND), .DIGIT_CNT_W(CW)) dut (
        .clk         (clk),
        .rst         (rst),
        .value       (value),
        .dp_in       (dp_in),
        .blank_in    (blank_in),
        .hex_en      (hex_en),
        .lzs_en      (lzs_en),
        .load        (load),
        .bright      (bright),
        .busy        (busy),
        .frame_start (frame_start),
        .an          (an),
        .sseg        (sseg),
        .dp          (dp)
    );

    logic [6:0] font [16] = '{
        7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
        7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
        7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
        7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
    };

    // Model state: t counts cycles since reset release; digit and phase follow from it.
    int          t;
    logic [15:0] m_val, s_val;
    logic [3:0]  m_dp, s_dp, m_blk, s_blk;
    logic        m_hex, s_hex, m_lzs, s_lzs, m_busy;
    logic [3:0]  e_an;
    logic [6:0]  e_sseg;
    logic        e_dp, e_fs;

    function automatic logic [11:0] model_out(input int tc, input logic [15:0] v,
            input logic [3:0] dpv, input logic [3:0] blk, input logic hx,
            input logic lz, input logic [3:0] br);
        int         d;
        int         ph;
        logic [3:0] code;
        logic       drk;
        logic [3:0] a;
        logic [6:0] s;
        d    = (tc / DWELL) % ND;
        ph   = tc % DWELL;
        code = 4'((v >> (4 * d)) & 16'h000F);
        drk  = blk[d] || (lz && d > 0 && (v >> (4 * d)) == 16'd0);
        if (drk) return {4'hF, 7'h7F, 1'b1};
        a = (ph <= int'(br)) ? ~(4'b0001 << d) : 4'hF;
        s = (hx || code < 4'd10) ? font[code] : font[0];
        return {a, s, ~dpv[d]};
    endfunction

    always @(posedge clk) begin
        if (rst) begin
            t <= 0;
            m_val <= '0; m_dp <= '0; m_blk <= 4'hF; m_hex <= 1'b0; m_lzs <= 1'b0;
            s_val <= '0; s_dp <= '0; s_blk <= 4'hF; s_hex <= 1'b0; s_lzs <= 1'b0;
            m_busy <= 1'b0;
            {e_an, e_sseg, e_dp} <= {4'hF, 7'h7F, 1'b1};
            e_fs <= 1'b0;
        end else begin
            {e_an, e_sseg, e_dp} <= model_out(t, m_val, m_dp, m_blk, m_hex, m_lzs, bright);
            e_fs <= (t % FRAME == 0);
            t    <= t + 1;
            if (load && (t == 0 || t % FRAME == FRAME - 1)) begin
                m_val <= value; m_dp <= dp_in; m_blk <= blank_in;
                m_hex <= hex_en; m_lzs <= lzs_en; m_busy <= 1'b0;
            end else if (load) begin
                s_val <= value; s_dp <= dp_in; s_blk <= blank_in;
                s_hex <= hex_en; s_lzs <= lzs_en; m_busy <= 1'b1;
            end else if ((t == 0 || t % FRAME == FRAME - 1) && m_busy) begin
                m_val <= s_val; m_dp <= s_dp; m_blk <= s_blk;
                m_hex <= s_hex; m_lzs <= s_lzs; m_busy <= 1'b0;
            end
        end
    end

    task automatic do_load(input logic [15:0] v, input logic [3:0] d, input logic [3:0] b,
                           input logic h, input logic l);
        value = v; dp_in = d; blank_in = b; hex_en = h; lzs_en = l;
        load = 1'b1;
        @(negedge clk);
        load = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; load = 1'b0; value = '0; dp_in = '0; blank_in = '0;
        hex_en = 1'b0; lzs_en = 1'b0; bright = 4'd15;
        repeat (2) @(negedge clk);
        checks++;
        if ({an, sseg, dp, busy, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL reset_state: got an=%b sseg=%b dp=%b busy=%b fs=%b, want an=1111 sseg=1111111 dp=1 busy=0 fs=0",
                     an, sseg, dp, busy, frame_start);
        else passes++;
    endtask

    task automatic test_counter();
        int fs_seen;
        fs_seen = 0;
        rst = 1'b0;
        for (int i = 0; i < 140; i++) begin
            @(negedge clk);
            if (frame_start === 1'b1) fs_seen++;
            checks++;
            if ({an, frame_start} !== {4'hF, e_fs})
                $display("[TB] FAIL counter cyc %0d: got an=%b fs=%b, want an=1111 fs=%b", i, an, frame_start, e_fs);
            else passes++;
        end
        checks++;
        if (fs_seen !== 3)
            $display("[TB] FAIL frame_start_count: got %0d, want 3", fs_seen);
        else passes++;
    endtask

    task automatic run_checked(input string name, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({an, sseg, dp, busy, frame_start} !== {e_an, e_sseg, e_dp, m_busy, e_fs})
                $display("[TB] FAIL %s cyc %0d: got an=%b sseg=%b dp=%b busy=%b fs=%b, want an=%b sseg=%b dp=%b busy=%b fs=%b",
                         name, i, an, sseg, dp, busy, frame_start, e_an, e_sseg, e_dp, m_busy, e_fs);
            else passes++;
        end
    endtask

    task automatic test_scan();
        bright = 4'd15;
        do_load(16'h1234, 4'($urandom), 4'h0, 1'b1, 1'b0);
        run_checked("scan", 2 * FRAME + 8);
    endtask

    task automatic test_hex();
        do_load(16'h00AF, 4'($urandom), 4'h0, 1'b1, 1'b1);
        run_checked("hex_on", FRAME + 70);
        do_load(16'h00AF, 4'($urandom), 4'h0, 1'b0, 1'b1);
        run_checked("hex_off", FRAME + 70);
    endtask

    task automatic test_tearing();
        run_checked("tear_align", int'($urandom_range(5, 30)));
        do_load(16'($urandom), 4'($urandom), 4'h0, 1'b1, 1'($urandom));
        checks++;
        if (busy !== 1'b1)
            $display("[TB] FAIL tear_busy: got busy=%b, want 1", busy);
        else passes++;
        run_checked("tear_pending", 10);
        do_load(16'($urandom), 4'($urandom), 4'h0, 1'b1, 1'($urandom));
        run_checked("tear_commit", FRAME + 40);
    endtask

    task automatic test_pwm();
        bright = 4'd0;
        run_checked("pwm0", FRAME);
        bright = 4'd7;
        run_checked("pwm7", FRAME);
        for (int k = 0; k < 8; k++) begin
            bright = 4'($urandom);
            run_checked("pwm_rand", DWELL);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 19) == 0)
                do_load(16'($urandom), 4'($urandom), ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'h0,
                        1'($urandom), 1'($urandom));
            if ($urandom_range(0, 31) == 0) bright = 4'($urandom);
            run_checked("random", 1);
        end
    endtask

    task automatic test_reset_mid();
        run_checked("rst_align", int'($urandom_range(3, 20)));
        do_load(16'($urandom), 4'hF, 4'h0, 1'b1, 1'b0);
        run_checked("rst_pending", 3);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({an, sseg, dp, busy, frame_start} !== {4'hF, 7'h7F, 1'b1, 1'b0, 1'b0})
            $display("[TB] FAIL reset_mid: got an=%b sseg=%b dp=%b busy=%b fs=%b, want an=1111 sseg=1111111 dp=1 busy=0 fs=0",
                     an, sseg, dp, busy, frame_start);
        else passes++;
        rst = 1'b0;
        run_checked("after_reset", FRAME + 20);
    endtask

    initial begin
        test_reset();
        test_counter();
        test_scan();
        test_hex();
        test_tearing();
        test_pwm();
        test_back_to_back();
        test_reset_mid();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
